// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the memory-stage load/store unit.
//   - lsu_state_e : access sequencer states
//   - OP_LOAD / OP_STORE : major opcodes that select a memory access
//   - F3_* : func3 encodings for access size and signedness
//   - byte_en() : byte-lane mask for a given size and byte offset
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // size: func3[1:0] (00 byte, 01 half, others word); off: address bits [1:0]
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
// Ports:
//   func3      in  3  : access size / signedness
//   addr_lo    in  2  : byte offset within the word
//   is_store   in  1  : access is a store (LBU/LHU encodings are illegal then)
//   store_data in  32 : right-justified store data
//   rdata      in  32 : raw word returned by the bus
//   be         out 4  : byte enables
//   wdata      out 32 : store data shifted onto its byte lanes
//   load_data  out 32 : selected lane, sign- or zero-extended
//   fault      out 1  : illegal func3 or misaligned address
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        fault
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        illegal;
  logic        misalign;

  assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
  // Halfwords are only ever aligned here, so addr_lo[1] alone picks the lane.
  assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    illegal = 1'b0;
    case (func3)
      F3_LB, F3_LH, F3_LW: illegal = 1'b0;
      F3_LBU, F3_LHU:      illegal = is_store;
      default:             illegal = 1'b1;
    endcase
  end

  assign misalign = ((func3[1:0] == 2'b01) && addr_lo[0]) ||
                    ((func3[1:0] == 2'b10) && (addr_lo != 2'b00));
  assign fault    = illegal | misalign;

  assign be    = byte_en(func3[1:0], addr_lo);
  assign wdata = store_data << {addr_lo, 3'b000};

  always_comb begin
    load_data = '0;
    case (func3)
      F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      F3_LW:   load_data = rdata;
      F3_LBU:  load_data = {24'd0, lane_b};
      F3_LHU:  load_data = {16'd0, lane_h};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit. Turns the load or store held in
// the EX/MEM register into one valid/ready bus request, stalls the pipeline
// until the access finishes and returns extended load data to writeback.
// Optional feature macro: LSU_TIMEOUT_EN (WAIT watchdog, drives bus_error_o).
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   alu_out_m, write_data_m : effective byte address, right-justified store data
//   opcode_m, func3_m       : instruction opcode and access size/signedness
//   mem_write_m             : store qualifier
//   stall_o                 : hold request for EX/MEM and upstream registers
//   load_data_o             : registered, extended load result
//   access_fault_o          : one-cycle pulse on misalignment / illegal func3
//   bus_error_o             : one-cycle pulse on watchdog timeout
//   req_*                   : request channel (valid/ready, addr, we, be, wdata)
//   rsp_valid_i, rsp_rdata_i: response channel (read data or write ack)
// Request fields are decoded from the EX/MEM inputs, which the stall holds
// steady for the whole access.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] alu_out_m,
  input  logic [DW-1:0] write_data_m,
  input  logic [6:0]    opcode_m,
  input  logic [2:0]    func3_m,
  input  logic          mem_write_m,
  output logic          stall_o,
  output logic [DW-1:0] load_data_o,
  output logic          access_fault_o,
  output logic          bus_error_o,
  output logic          req_valid_o,
  input  logic          req_ready_i,
  output logic [DW-1:0] req_addr_o,
  output logic          req_we_o,
  output logic [3:0]    req_be_o,
  output logic [DW-1:0] req_wdata_o,
  input  logic          rsp_valid_i,
  input  logic [DW-1:0] rsp_rdata_i
);

  if (DW != 32) begin : g_dw_chk
    $error("mem_stage_lsu: only DW=32 is supported");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
    $error("mem_stage_lsu: TIMEOUT_CYCLES must be at least 1");
  end

  lsu_state_e    state_q, state_d;
  logic          is_load, is_store, mem_op;
  logic          align_fault, fault_start, timeout;
  logic [DW-1:0] ext_data;
  logic [DW-1:0] load_data_q;
  logic          fault_q, req_valid_q;

  assign is_load  = (opcode_m == OP_LOAD);
  assign is_store = (opcode_m == OP_STORE) && mem_write_m;
  assign mem_op   = is_load || is_store;

  lsu_align u_align (
    .func3      (func3_m),
    .addr_lo    (alu_out_m[1:0]),
    .is_store   (is_store),
    .store_data (write_data_m),
    .rdata      (rsp_rdata_i),
    .be         (req_be_o),
    .wdata      (req_wdata_o),
    .load_data  (ext_data),
    .fault      (align_fault)
  );

  assign fault_start = (state_q == IDLE) && mem_op && align_fault;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             bus_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      if ((state_q == REQ) && req_ready_i) wait_cnt_q <= '0;
      else if (state_q == WAIT)            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      bus_err_q <= (state_q == WAIT) && !rsp_valid_i && timeout;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle without a response.
  assign timeout     = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_error_o = bus_err_q;
`else
  assign timeout     = 1'b0;
  assign bus_error_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op) state_d = align_fault ? DONE : REQ;
      REQ:     if (req_ready_i) state_d = WAIT;
      WAIT:    if (rsp_valid_i || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= (state_d == REQ);
      fault_q     <= fault_start;
      if (fault_start || ((state_q == WAIT) && !rsp_valid_i && timeout))
        load_data_q <= '0;
      else if ((state_q == WAIT) && rsp_valid_i)
        load_data_q <= is_load ? ext_data : '0;
    end
  end

  // DONE drops the stall so the EX/MEM register can advance without re-issue.
  assign stall_o        = ((state_q == IDLE) && mem_op) || (state_q == REQ) || (state_q == WAIT);
  assign req_valid_o    = req_valid_q;
  assign req_addr_o     = {alu_out_m[DW-1:2], 2'b00};
  assign req_we_o       = is_store;
  assign load_data_o    = load_data_q;
  assign access_fault_o = fault_q;

endmodule
